// File: rtl/mult_ctrl_param_if.sv
// Handshake and datapath-strobe bundle between the sequencer/datapath side (master)
// and the shift-add multiplier controller (slave).
interface mult_ctrl_param_if #(
    parameter int WIDTH = 4
);
    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);

    logic          start;
    logic          abort;
    logic          q_lsb;
    logic          ready;
    logic          busy;
    logic          done;
    logic          sig_rst;
    logic          ld1;
    logic          ld2;
    logic          s0;
    logic          s1;
    logic          s2;
    logic [CW-1:0] iter_cnt;

    modport master (
        output start, abort, q_lsb,
        input  ready, busy, done, sig_rst, ld1, ld2, s0, s1, s2, iter_cnt
    );

    modport slave (
        input  start, abort, q_lsb,
        output ready, busy, done, sig_rst, ld1, ld2, s0, s1, s2, iter_cnt
    );
endinterface

// File: rtl/mult_ctrl_param.sv
// Parametrised shift-add multiplier controller: start/ready/done handshake,
// synchronous abort and optional single-cycle handling of zero multiplier bits.
module mult_ctrl_param #(
    parameter int WIDTH     = 4,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_ctrl_param_if.slave  bus
);
    localparam int            CW   = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOAD,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_iter_cnt;
    logic [CW-1:0] w_iter_next;

    logic w_ready;
    logic w_done;
    logic w_sig_rst;
    logic w_ld1;
    logic w_ld2;
    logic w_s0;
    logic w_shift;
    logic w_last;
    logic w_skip;

    assign w_last = (r_iter_cnt == LAST);
    assign w_skip = SKIP_ZERO & ~bus.q_lsb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_iter_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_iter_cnt <= w_iter_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_iter_next = r_iter_cnt;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_sig_rst   = 1'b0;
        w_ld1       = 1'b0;
        w_ld2       = 1'b0;
        w_s0        = 1'b0;
        w_shift     = 1'b0;

        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_next = INIT;
                end
            end
            INIT: begin
                w_sig_rst   = 1'b1;
                w_iter_next = '0;
                w_next      = LOAD;
            end
            LOAD: begin
                w_ld1  = 1'b1;
                w_next = ADD;
            end
            ADD: begin
                if (w_skip) begin
                    // Zero bit in skip mode: shift right here instead of visiting SHIFT
                    w_ld2   = 1'b1;
                    w_shift = 1'b1;
                    if (w_last) begin
                        w_next = DONE;
                    end else begin
                        w_iter_next = r_iter_cnt + 1'b1;
                        w_next      = ADD;
                    end
                end else begin
                    w_ld2  = bus.q_lsb;
                    w_s0   = 1'b1;
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                w_ld2   = 1'b1;
                w_shift = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_iter_next = r_iter_cnt + 1'b1;
                    w_next      = ADD;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        // Abort overrides every transition, including DONE -> IDLE
        if (bus.abort && (r_state != IDLE)) begin
            w_next      = IDLE;
            w_iter_next = '0;
        end
    end

    assign bus.ready    = w_ready;
    assign bus.busy     = ~w_ready;
    assign bus.done     = w_done;
    assign bus.sig_rst  = w_sig_rst;
    assign bus.ld1      = w_ld1;
    assign bus.ld2      = w_ld2;
    assign bus.s0       = w_s0;
    assign bus.s1       = w_shift;
    assign bus.s2       = w_shift;
    assign bus.iter_cnt = r_iter_cnt;

    a_s2_matches_s1: assert property (@(posedge clk) disable iff (!rst_n)
        bus.s2 == bus.s1);
    a_strobes_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({bus.sig_rst, bus.ld1, bus.done}));
    a_iter_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        r_iter_cnt <= LAST);
    a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
        bus.done |=> !bus.done);
endmodule

// File: tb/tb_mult_ctrl_param.sv
// Scoreboard bench: three controllers (4-bit fixed, 4-bit zero-skip, 8-bit fixed)
// each driving a small shift-add datapath model whose product is checked on done.
module tb_mult_ctrl_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cycleCount = 0;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    int nVectors = 0;
    int nMiscompares = 0;
    int maxIter2 = 0;

    typedef struct {
        int          doneCycle;
        logic [15:0] product;
    } expect_t;

    expect_t q0[$];
    expect_t q1[$];
    expect_t q2[$];

    mult_ctrl_param_if #(.WIDTH(4)) if0();
    mult_ctrl_param_if #(.WIDTH(4)) if1();
    mult_ctrl_param_if #(.WIDTH(8)) if2();

    mult_ctrl_param #(.WIDTH(4), .SKIP_ZERO(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    mult_ctrl_param #(.WIDTH(4), .SKIP_ZERO(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mult_ctrl_param #(.WIDTH(8), .SKIP_ZERO(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    // Datapath models: {carry, high half, multiplier} shifted right as one register
    logic [3:0]  opA0, opB0, regA0;
    logic [8:0]  regP0;
    logic [3:0]  opA1, opB1, regA1;
    logic [8:0]  regP1;
    logic [7:0]  opA2, opB2, regA2;
    logic [16:0] regP2;

    assign if0.q_lsb = regP0[0];
    assign if1.q_lsb = regP1[0];
    assign if2.q_lsb = regP2[0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regP0 <= '0; regA0 <= '0;
        end else if (if0.sig_rst) begin
            regP0 <= '0;
        end else if (if0.ld1) begin
            regA0 <= opA0; regP0[3:0] <= opB0;
        end else if (if0.ld2 && if0.s0) begin
            regP0[8:4] <= {1'b0, regP0[7:4]} + {1'b0, regA0};
        end else if (if0.ld2 && if0.s1) begin
            regP0 <= regP0 >> 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regP1 <= '0; regA1 <= '0;
        end else if (if1.sig_rst) begin
            regP1 <= '0;
        end else if (if1.ld1) begin
            regA1 <= opA1; regP1[3:0] <= opB1;
        end else if (if1.ld2 && if1.s0) begin
            regP1[8:4] <= {1'b0, regP1[7:4]} + {1'b0, regA1};
        end else if (if1.ld2 && if1.s1) begin
            regP1 <= regP1 >> 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regP2 <= '0; regA2 <= '0;
        end else if (if2.sig_rst) begin
            regP2 <= '0;
        end else if (if2.ld1) begin
            regA2 <= opA2; regP2[7:0] <= opB2;
        end else if (if2.ld2 && if2.s0) begin
            regP2[16:8] <= {1'b0, regP2[15:8]} + {1'b0, regA2};
        end else if (if2.ld2 && if2.s1) begin
            regP2 <= regP2 >> 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int k, input logic [7:0] a, input logic [7:0] b,
                                 input logic [15:0] prod, input int lat, input bit expectDone);
        expect_t e;
        e.doneCycle = cycleCount + lat;
        e.product   = prod;
        case (k)
            0: begin opA0 = a[3:0]; opB0 = b[3:0]; if0.start = 1'b1; if (expectDone) q0.push_back(e); end
            1: begin opA1 = a[3:0]; opB1 = b[3:0]; if1.start = 1'b1; if (expectDone) q1.push_back(e); end
            default: begin opA2 = a; opB2 = b; if2.start = 1'b1; if (expectDone) q2.push_back(e); end
        endcase
        waitCycles(1);
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
    endtask

    function automatic logic [8:0] outs0();
        return {if0.ready, if0.busy, if0.done, if0.sig_rst, if0.ld1, if0.ld2, if0.s0, if0.s1, if0.s2};
    endfunction

    // Monitor: pops the scoreboard on every done and watches strobe invariants
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("inst0 s2==s1", 32'(if0.s2), 32'(if0.s1));
                checkOutput("inst1 s2==s1", 32'(if1.s2), 32'(if1.s1));
                checkOutput("inst0 strobe exclusivity", 32'($onehot0({if0.sig_rst, if0.ld1, if0.done})), 32'd1);
                checkOutput("inst1 strobe exclusivity", 32'($onehot0({if1.sig_rst, if1.ld1, if1.done})), 32'd1);
                if (32'(if2.iter_cnt) > maxIter2) maxIter2 = 32'(if2.iter_cnt);
                if (if0.done) begin
                    if (q0.size() == 0) checkOutput("inst0 unexpected done", 32'd1, 32'd0);
                    else begin
                        e = q0.pop_front();
                        checkOutput("inst0 done cycle", 32'(cycleCount), 32'(e.doneCycle));
                        checkOutput("inst0 product", 32'(regP0[7:0]), 32'(e.product));
                    end
                end
                if (if1.done) begin
                    if (q1.size() == 0) checkOutput("inst1 unexpected done", 32'd1, 32'd0);
                    else begin
                        e = q1.pop_front();
                        checkOutput("inst1 done cycle", 32'(cycleCount), 32'(e.doneCycle));
                        checkOutput("inst1 product", 32'(regP1[7:0]), 32'(e.product));
                    end
                end
                if (if2.done) begin
                    if (q2.size() == 0) checkOutput("inst2 unexpected done", 32'd1, 32'd0);
                    else begin
                        e = q2.pop_front();
                        checkOutput("inst2 done cycle", 32'(cycleCount), 32'(e.doneCycle));
                        checkOutput("inst2 product", 32'(regP2[15:0]), 32'(e.product));
                    end
                end
            end
        end
    end

    initial begin
        if0.start = 1'b0; if0.abort = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0;
        if2.start = 1'b0; if2.abort = 1'b0;
        opA0 = '0; opB0 = '0; opA1 = '0; opB1 = '0; opA2 = '0; opB2 = '0;

        #2;
        checkOutput("reset outputs", 32'(outs0()), 32'h100);
        checkOutput("reset iter_cnt", 32'(if0.iter_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        waitCycles(2);

        // Fixed latency 13*11
        applyStimulus(0, 8'd13, 8'd11, 16'd143, 11, 1'b1);
        checkOutput("INIT sig_rst", 32'(if0.sig_rst), 32'd1);
        waitCycles(1);
        checkOutput("LOAD ld1", 32'(if0.ld1), 32'd1);
        waitCycles(10);
        checkOutput("ready after done", 32'(if0.ready), 32'd1);
        checkOutput("iter_cnt held after done", 32'(if0.iter_cnt), 32'd3);

        // Abort in IDLE has no effect
        if0.abort = 1'b1;
        waitCycles(2);
        if0.abort = 1'b0;
        checkOutput("idle abort ready", 32'(if0.ready), 32'd1);
        checkOutput("idle abort iter_cnt", 32'(if0.iter_cnt), 32'd3);

        // Start pulses while busy are ignored
        applyStimulus(0, 8'd5, 8'd6, 16'd30, 11, 1'b1);
        waitCycles(2);
        if0.start = 1'b1;
        waitCycles(1);
        if0.start = 1'b0;
        waitCycles(2);
        if0.start = 1'b1;
        waitCycles(1);
        if0.start = 1'b0;
        waitCycles(14);

        // Start held high: back-to-back ops with one IDLE cycle between
        begin
            expect_t e;
            opA0 = 4'd9; opB0 = 4'd7;
            e.product = 16'd63;
            e.doneCycle = cycleCount + 11; q0.push_back(e);
            e.doneCycle = cycleCount + 23; q0.push_back(e);
            if0.start = 1'b1;
            waitCycles(13);
            if0.start = 1'b0;
            waitCycles(12);
            checkOutput("held start ready", 32'(if0.ready), 32'd1);
        end

        // Abort during ADD with iter_cnt=2 (bit 2 of 1011 is 0)
        applyStimulus(0, 8'd13, 8'd11, 16'd0, 0, 1'b0);
        waitCycles(6);
        checkOutput("ADD strobes before abort", 32'({if0.ld2, if0.s0, if0.s1}), 32'b010);
        checkOutput("iter_cnt before abort", 32'(if0.iter_cnt), 32'd2);
        if0.abort = 1'b1;
        waitCycles(1);
        if0.abort = 1'b0;
        checkOutput("abort ready", 32'(if0.ready), 32'd1);
        checkOutput("abort iter_cnt", 32'(if0.iter_cnt), 32'd0);
        waitCycles(14);

        // Async reset during the SHIFT with iter_cnt=2
        applyStimulus(0, 8'd13, 8'd11, 16'd0, 0, 1'b0);
        waitCycles(7);
        checkOutput("SHIFT before reset", 32'({if0.s1, if0.iter_cnt}), 32'h6);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset outputs", 32'(outs0()), 32'h100);
        checkOutput("async reset iter_cnt", 32'(if0.iter_cnt), 32'd0);
        rst_n = 1'b1;
        waitCycles(15);

        // Zero-skip latencies
        applyStimulus(1, 8'd7, 8'b0101, 16'd35, 9, 1'b1);
        waitCycles(10);
        applyStimulus(1, 8'd9, 8'b0000, 16'd0, 7, 1'b1);
        waitCycles(8);
        applyStimulus(1, 8'd15, 8'b1111, 16'd225, 11, 1'b1);
        waitCycles(12);

        // Wide build
        applyStimulus(2, 8'hFF, 8'hFF, 16'hFE01, 19, 1'b1);
        waitCycles(20);
        checkOutput("inst2 iter_cnt peak", 32'(maxIter2), 32'd7);
        checkOutput("inst2 iter_cnt idle", 32'(if2.iter_cnt), 32'd7);
        checkOutput("inst2 ready", 32'(if2.ready), 32'd1);

        checkOutput("inst0 pending dones", 32'(q0.size()), 32'd0);
        checkOutput("inst1 pending dones", 32'(q1.size()), 32'd0);
        checkOutput("inst2 pending dones", 32'(q2.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule

// File: doc/mult_ctrl_param.md
Name: mult_ctrl_param

Overview:
Parametrised control unit for the shift-add multiplier, replacing the fixed 4x4 controller.
- Owns its state register and iteration counter, and drives the existing datapath control strobes (sig_rst, ld1, ld2, s0, s1, s2).
- Adds a start/ready/done handshake, a synchronous abort, and an optional zero-skip mode that shortens latency for sparse multipliers.
- Sits between the top-level sequencer and the multiplier datapath.

Parameters:
- WIDTH, 4, operand width in bits and number of iterations; legal range 2..32.
- SKIP_ZERO, 0, 1 = a zero multiplier bit costs one cycle instead of two.
- CW, $clog2(WIDTH) (minimum 1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a multiply; sampled only in IDLE
- abort  in  1  synchronous cancel; effective in any non-IDLE state
- q_lsb  in  1  current multiplier LSB from the datapath; valid from the cycle after LOAD onward
- ready  out  1  high only in IDLE
- busy  out  1  inverse of ready
- done  out  1  one-cycle pulse; product valid in the datapath
- sig_rst  out  1  clear product register
- ld1  out  1  load operand registers
- ld2  out  1  write product/accumulator register
- s0  out  1  accumulator mux select: 1 = adder output, 0 = shifted value
- s1  out  1  shift enable for product and multiplier registers
- s2  out  1  identical to s1, kept as a separate port for the datapath
- iter_cnt  out  CW  current iteration index, 0..WIDTH-1

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, iter_cnt = 0.
  - ready = 1; busy, done, sig_rst, ld1, ld2, s0, s1, s2 = 0.
  - Holds while rst_n is low; reset mid-operation discards the operation with no done pulse.
- Outputs:
  - Decoded combinationally from the state; only ld2/s0/s1 in ADD also depend on q_lsb.
  - State and iter_cnt are registered; no other registered outputs.
- States: IDLE, INIT, LOAD, ADD, SHIFT, DONE. Binary encoding is free.
- IDLE: ready = 1. start = 1 -> INIT; otherwise stay.
- INIT: sig_rst = 1; iter_cnt <= 0. Next: LOAD.
- LOAD: ld1 = 1. Next: ADD.
- ADD, normal case (q_lsb = 1, either mode): ld2 = 1, s0 = 1. Next: SHIFT.
- ADD, SKIP_ZERO = 0 and q_lsb = 0: ld2 = 0, s0 = 1. Next: SHIFT.
  - Fixed latency of 2 cycles per bit.
- ADD, SKIP_ZERO = 1 and q_lsb = 0: performs the shift in place.
  - ld2 = 1, s0 = 0, s1 = s2 = 1; iter_cnt increments.
  - Next: DONE if iter_cnt == WIDTH-1, else ADD.
- SHIFT: ld2 = 1, s0 = 0, s1 = s2 = 1; iter_cnt increments.
  - Next: DONE if iter_cnt == WIDTH-1, else ADD.
- DONE: done = 1 for exactly one cycle. Next: IDLE.
- iter_cnt:
  - Never exceeds WIDTH-1; the last iteration does not increment past WIDTH-1.
  - Cleared in INIT and on abort.
  - Holds its value in IDLE after completion; reads as WIDTH-1 until the next INIT.
- start:
  - Ignored outside IDLE; a start held high through DONE is accepted again in the following IDLE cycle.
  - A start that is high on the same cycle rst_n deasserts is sampled normally at the next edge.
- abort:
  - When high in any non-IDLE state: next state = IDLE, iter_cnt <= 0, no done pulse.
  - Takes priority over all other transitions, including DONE -> IDLE, which still yields no extra pulse.
  - Ignored in IDLE.
- Latency, with N = the IDLE cycle in which start is sampled:
  - SKIP_ZERO = 0: done is high in cycle N+3+2*WIDTH; ready returns in cycle N+4+2*WIDTH.
  - SKIP_ZERO = 1: done is high in cycle N+3+WIDTH+ones, where ones = number of 1 bits in the multiplier.
- s2 is always equal to s1.
- No more than one of sig_rst, ld1, done is ever high in the same cycle.

Test Plan:
- Fixed latency: WIDTH=4, SKIP_ZERO=0, A=4'd13, B=4'd11, start pulse in cycle N -> INIT@N+1, LOAD@N+2, done only in cycle N+11, datapath product 8'd143, ready back in cycle N+12.
- Zero-skip: WIDTH=4, SKIP_ZERO=1, B=4'b0101 -> done in cycle N+9; B=4'b0000 -> done in N+7; B=4'b1111 -> done in N+11; products correct in all three cases.
- Start while busy: second start pulses at N+3 and N+6 -> ignored, exactly one done pulse; start held high continuously -> back-to-back operations separated by exactly one IDLE cycle.
- Abort: abort in an ADD cycle with iter_cnt=2 -> IDLE next cycle, iter_cnt=0, no done, ready=1; abort asserted in IDLE -> no effect.
- Async reset mid-operation: rst_n low for 1 ns in a SHIFT cycle -> ready=1, all strobes 0 and iter_cnt=0 immediately (no clock edge needed); no done pulse afterwards.
- Wide build: WIDTH=8, SKIP_ZERO=0, A=8'hFF, B=8'hFF -> done in cycle N+19, product 16'hFE01, iter_cnt peaks at 7 and never reaches 8.
